attn_coef_unit: RTL and testbench
=================================

Name: attn_coef_unit

Overview:
- Stage directly downstream of the WH scheduler.
- Reads packed WH rows from read port c of the dual-read WH BRAM and the 32-entry attention vector a from the a BRAM.
- For each subgraph it computes the unnormalised attention coefficient e_j = a_src·Wh_src + a_dst·Wh_j, one per row.
- Results are streamed to the softmax stage over a valid/ready interface.

Parameters:
- DATA_WIDTH, 8, signed feature/weight width.
- W_NUM_OF_COLS, 16, features per WH row.
- NUM_OF_NODES, 168, maximum nodes per subgraph.
- WH_DEPTH, 242101, WH BRAM rows.
- A_DEPTH, 32, a-vector length; always 2*W_NUM_OF_COLS.
- NUM_NODE_WIDTH, $clog2(NUM_OF_NODES), width of the node-count field.
- WH_WIDTH, DATA_WIDTH*W_NUM_OF_COLS+NUM_NODE_WIDTH+1, packed row width.
- WH_ADDR_W, $clog2(WH_DEPTH), WH address width.
- A_ADDR_W, $clog2(A_DEPTH), a address width.
- COEF_WIDTH, 2*DATA_WIDTH+$clog2(W_NUM_OF_COLS)+1, coefficient width (21 at defaults).

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, synchronous active-low.
- a_BRAM_dout, in, DATA_WIDTH: a-vector read data, 1-cycle latency.
- a_BRAM_addrb, out, A_ADDR_W: a-vector read address.
- a_BRAM_load_done, in, 1: a BRAM is filled (level).
- WH_BRAM_doutc, in, WH_WIDTH: WH read data, 1-cycle latency.
- WH_BRAM_addrc, out, WH_ADDR_W: WH read address.
- WH_BRAM_load_done, in, 1: scheduler has finished writing WH (level).
- WH_num_rows, in, WH_ADDR_W: number of valid WH rows; sampled when leaving WAIT_WH.
- coef_dout, out, COEF_WIDTH: signed coefficient.
- coef_valid, out, 1: coef_dout is valid.
- coef_ready, in, 1: downstream accepts the coefficient.
- coef_last, out, 1: last coefficient of the current subgraph.
- done, out, 1: all rows processed; sticky until reset.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset state: while rst_n=0 on a clk edge, all outputs and internal state are 0, FSM=IDLE, a_vec is cleared. Reset asserted mid-operation aborts immediately; no partial output survives.
- WH row packing:
  - feature k (k=0..15) occupies bits [WH_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH];
  - num_nodes occupies [NUM_NODE_WIDTH:1];
  - bit 0 is the source flag.
- FSM transitions:
  - IDLE -> LOAD_A when a_BRAM_load_done=1.
  - LOAD_A: issue addresses 0..31, one per cycle. Capture a_BRAM_dout one cycle after each address into a_vec[i]. Takes 33 cycles, then WAIT_WH.
  - WAIT_WH: wait for WH_BRAM_load_done=1. Latch WH_num_rows and set row=0. If WH_num_rows=0 go to DONE, else READ.
  - READ: drive WH_BRAM_addrc=row, then LATCH.
  - LATCH: register WH_BRAM_doutc, then CALC.
  - CALC: compute and register the coefficient (see scoring rules below), then OUT.
  - OUT: assert coef_valid. Hold coef_dout and coef_last stable until coef_ready=1. On the handshake cycle: row++. If row == latched count go to DONE, else READ.
  - DONE: done=1 and coef_valid=0; stays until reset.
- Scoring in CALC:
  - s_dst = Σ a_vec[16+k]*f_k; s_src = Σ a_vec[k]*f_k.
  - Arithmetic is signed, full precision, no truncation or saturation.
  - Flag=1: latch s_src as src_score, latch group size from num_nodes, reset group counter cnt to 1.
  - Flag=0: cnt++.
  - Coefficient = src_score + s_dst, sign-extended to COEF_WIDTH.
  - coef_last = (cnt == group size).
- Throughput: 4 cycles per row when coef_ready is held high. Latency from READ entry to coef_valid is 3 cycles.
- Boundary conditions:
  - num_nodes=1: single-row group; coef_last=1 on the source row.
  - First row with flag=0: src_score=0 and group size=0, so coef_last=0 until the next flag=1 row.
  - Flag=1 arriving before the previous group completes: starts a new group; no error is raised.
  - a_BRAM_load_done or WH_BRAM_load_done dropping after being sampled: ignored.
  - coef_ready=1 while coef_valid=0: ignored.

Optional Feature:
- Macro: LEAKY_RELU_EN.
- Defined: in CALC, a negative coefficient becomes coef>>>3 (arithmetic shift, slope 1/8); non-negative values pass unchanged. No change to latency.
- Undefined: the raw coefficient is output.

Decomposition:
- Package gat_pkg holds: the FSM state enum; WH field offset constants (FEAT_MSB(k), NODE_LSB=1, FLAG_BIT=0); the COEF_WIDTH formula; the LeakyReLU shift constant 3.
- Sub-module dot16: a combinational signed dot product of 16 DATA_WIDTH pairs producing a 2*DATA_WIDTH+4 bit result. Instantiated twice, for the src and dst halves of a_vec.

Test Plan:
- Load a=all 1; one row, flag=1, num_nodes=1, features all 2 -> coef_dout=64, coef_last=1, done=1 after handshake.
- a[0..15]=1, a[16..31]=-1; group of 3 rows, features 1, 2, 3 (all lanes) -> coef = 16-16=0, 16-32=-16, 16-48=-32; coef_last only on the 3rd.
- Extremes: all a=-128 and all features=-128 -> coef=524288, no overflow at COEF_WIDTH=21.
- Hold coef_ready=0 for 10 cycles in OUT -> coef_dout, coef_valid and coef_last stable; WH_BRAM_addrc unchanged.
- WH_num_rows=0 -> done asserted directly after WAIT_WH; coef_valid never asserted.
- With LEAKY_RELU_EN: coef -32 -> -4; 16 -> 16. Reset mid-OUT -> all outputs 0 on the next clk, FSM=IDLE.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types and WH row field layout for the attention coefficient stage.
// The optional LeakyReLU output activation is enabled by LEAKY_RELU_EN.
package gat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    WAIT_WH,
    READ,
    LATCH,
    CALC,
    OUT,
    DONE
  } state_t;

  localparam int NODE_LSB    = 1;
  localparam int FLAG_BIT    = 0;
  localparam int LRELU_SHIFT = 3;

  // Feature k sits at the top of the row, feature 0 first.
  function automatic int feat_msb(int wh_w, int dw, int k);
    return wh_w - 1 - k * dw;
  endfunction

  function automatic int coef_w(int dw, int ncols);
    return 2 * dw + $clog2(ncols) + 1;
  endfunction

endpackage

// File: rtl/attn_coef_unit_if.sv
// Valid/ready coefficient stream from the attention stage to softmax.
// Master drives data/valid/last, slave returns ready.
interface attn_coef_unit_if #(
  parameter int W = 21
);
  logic signed [W-1:0] coef_dout;
  logic                coef_valid;
  logic                coef_ready;
  logic                coef_last;

  modport master (
    output coef_dout,
    output coef_valid,
    output coef_last,
    input  coef_ready
  );

  modport slave (
    input  coef_dout,
    input  coef_valid,
    input  coef_last,
    output coef_ready
  );
endinterface

// File: rtl/dot16.sv
// Combinational signed dot product of 16 DW-bit pairs.
// The result width holds the full-precision sum without overflow.
module dot16 #(
  parameter int DW = 8
) (
  input  logic [16*DW-1:0]        i_a,
  input  logic [16*DW-1:0]        i_b,
  output logic signed [2*DW+3:0]  o_dot
);

  logic signed [2*DW+3:0] w_ae;
  logic signed [2*DW+3:0] w_be;

  always_comb begin
    o_dot = '0;
    w_ae  = '0;
    w_be  = '0;
    for (int k = 0; k < 16; k++) begin
      w_ae  = {{(DW+4){i_a[k*DW+DW-1]}}, i_a[k*DW +: DW]};
      w_be  = {{(DW+4){i_b[k*DW+DW-1]}}, i_b[k*DW +: DW]};
      o_dot = o_dot + w_ae * w_be;
    end
  end

endmodule

// File: rtl/attn_coef_unit.sv
// Attention coefficient stage: e_j = a_src.Wh_src + a_dst.Wh_j per WH row.
// Define LEAKY_RELU_EN to apply a 1/8-slope LeakyReLU to each coefficient.
module attn_coef_unit
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int W_NUM_OF_COLS  = 16,
  parameter int NUM_OF_NODES   = 168,
  parameter int WH_DEPTH       = 242101,
  parameter int A_DEPTH        = 32,
  parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
  parameter int WH_WIDTH       = DATA_WIDTH*W_NUM_OF_COLS+NUM_NODE_WIDTH+1,
  parameter int WH_ADDR_W      = $clog2(WH_DEPTH),
  parameter int A_ADDR_W       = $clog2(A_DEPTH),
  parameter int COEF_WIDTH     = coef_w(DATA_WIDTH, W_NUM_OF_COLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a_BRAM_dout,
  output logic [A_ADDR_W-1:0]          a_BRAM_addrb,
  input  logic                         a_BRAM_load_done,
  input  logic [WH_WIDTH-1:0]          WH_BRAM_doutc,
  output logic [WH_ADDR_W-1:0]         WH_BRAM_addrc,
  input  logic                         WH_BRAM_load_done,
  input  logic [WH_ADDR_W-1:0]         WH_num_rows,
  attn_coef_unit_if.master             coef,
  output logic                         done
);

  localparam int DOT_W  = 2*DATA_WIDTH+4;
  localparam int CNT_W  = NUM_NODE_WIDTH;
  localparam int ACNT_W = A_ADDR_W+1;
  localparam int VEC_W  = W_NUM_OF_COLS*DATA_WIDTH;

  state_t r_state;
  state_t w_next;

  logic [ACNT_W-1:0]            r_a_cnt;
  logic signed [DATA_WIDTH-1:0] r_a_vec [A_DEPTH];
  logic [WH_ADDR_W-1:0]         r_row;
  logic [WH_ADDR_W-1:0]         r_nrows;
  logic [WH_WIDTH-1:0]          r_wh;
  logic signed [DOT_W-1:0]      r_src;
  logic [CNT_W-1:0]             r_grp;
  logic [CNT_W-1:0]             r_cnt;
  logic signed [COEF_WIDTH-1:0] r_coef;
  logic                         r_last;

  logic [A_ADDR_W-1:0]          w_a_idx;
  logic [WH_ADDR_W-1:0]         w_row_inc;
  logic                         w_a_end;
  logic [VEC_W-1:0]             w_fv;
  logic [VEC_W-1:0]             w_as;
  logic [VEC_W-1:0]             w_ad;
  logic signed [DOT_W-1:0]      w_s_src;
  logic signed [DOT_W-1:0]      w_s_dst;
  logic                         w_flag;
  logic [CNT_W-1:0]             w_nodes;
  logic [CNT_W-1:0]             w_cnt_nx;
  logic [CNT_W-1:0]             w_grp_nx;
  logic signed [DOT_W-1:0]      w_base;
  logic signed [COEF_WIDTH-1:0] w_sum;
  logic signed [COEF_WIDTH-1:0] w_act;

  assign w_a_idx   = r_a_cnt[A_ADDR_W-1:0] - A_ADDR_W'(1);
  assign w_a_end   = (r_a_cnt == ACNT_W'(A_DEPTH));
  assign w_row_inc = r_row + WH_ADDR_W'(1);

  always_comb begin
    w_fv = '0;
    w_as = '0;
    w_ad = '0;
    for (int k = 0; k < W_NUM_OF_COLS; k++) begin
      w_fv[k*DATA_WIDTH +: DATA_WIDTH] =
        r_wh[feat_msb(WH_WIDTH, DATA_WIDTH, k) -: DATA_WIDTH];
      w_as[k*DATA_WIDTH +: DATA_WIDTH] = r_a_vec[k];
      w_ad[k*DATA_WIDTH +: DATA_WIDTH] = r_a_vec[W_NUM_OF_COLS+k];
    end
  end

  dot16 #(.DW(DATA_WIDTH)) u_dot_src (
    .i_a   (w_as),
    .i_b   (w_fv),
    .o_dot (w_s_src)
  );

  dot16 #(.DW(DATA_WIDTH)) u_dot_dst (
    .i_a   (w_ad),
    .i_b   (w_fv),
    .o_dot (w_s_dst)
  );

  // A flagged row opens a new group and becomes its source score.
  assign w_flag   = r_wh[FLAG_BIT];
  assign w_nodes  = r_wh[NODE_LSB +: CNT_W];
  assign w_cnt_nx = w_flag ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_grp_nx = w_flag ? w_nodes : r_grp;
  assign w_base   = w_flag ? w_s_src : r_src;
  assign w_sum    = COEF_WIDTH'(w_base) + COEF_WIDTH'(w_s_dst);

`ifdef LEAKY_RELU_EN
  assign w_act = w_sum[COEF_WIDTH-1] ? (w_sum >>> LRELU_SHIFT) : w_sum;
`else
  assign w_act = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (a_BRAM_load_done) w_next = LOAD_A;
      LOAD_A:  if (w_a_end) w_next = WAIT_WH;
      WAIT_WH: if (WH_BRAM_load_done)
                 w_next = (WH_num_rows == '0) ? DONE : READ;
      READ:    w_next = LATCH;
      LATCH:   w_next = CALC;
      CALC:    w_next = OUT;
      OUT:     if (coef.coef_ready)
                 w_next = (w_row_inc == r_nrows) ? DONE : READ;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_cnt <= '0;
      r_row   <= '0;
      r_nrows <= '0;
      r_wh    <= '0;
      r_src   <= '0;
      r_grp   <= '0;
      r_cnt   <= '0;
      r_coef  <= '0;
      r_last  <= 1'b0;
      for (int i = 0; i < A_DEPTH; i++) r_a_vec[i] <= '0;
    end else begin
      case (r_state)
        LOAD_A: begin
          // Read data trails its address by one cycle.
          if (r_a_cnt != '0) r_a_vec[w_a_idx] <= a_BRAM_dout;
          r_a_cnt <= w_a_end ? '0 : r_a_cnt + ACNT_W'(1);
        end
        WAIT_WH: begin
          if (WH_BRAM_load_done) begin
            r_nrows <= WH_num_rows;
            r_row   <= '0;
          end
        end
        LATCH: r_wh <= WH_BRAM_doutc;
        CALC: begin
          r_src  <= w_base;
          r_grp  <= w_grp_nx;
          r_cnt  <= w_cnt_nx;
          r_coef <= w_act;
          r_last <= (w_cnt_nx == w_grp_nx);
        end
        OUT: if (coef.coef_ready) r_row <= w_row_inc;
        default: ;
      endcase
    end
  end

  assign a_BRAM_addrb    = r_a_cnt[A_ADDR_W-1:0];
  assign WH_BRAM_addrc   = r_row;
  assign coef.coef_dout  = r_coef;
  assign coef.coef_valid = (r_state == OUT);
  assign coef.coef_last  = r_last;
  assign done            = (r_state == DONE);

endmodule

// File: tb/tb_attn_coef_unit.sv
// Self-checking bench for attn_coef_unit with BRAM models and a
// row-level reference model of the attention coefficient rules.
module tb_attn_coef_unit;
  import gat_pkg::*;

  localparam int DW  = 8;
  localparam int NC  = 16;
  localparam int WHW = 137;
  localparam int WHA = 18;
  localparam int AAW = 5;
  localparam int CW  = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] a_dout;
  logic [AAW-1:0]       a_addrb;
  logic                 a_ld;
  logic [WHW-1:0]       wh_doutc;
  logic [WHA-1:0]       wh_addrc;
  logic                 wh_ld;
  logic [WHA-1:0]       wh_nrows;
  logic                 done;

  attn_coef_unit_if #(.W(CW)) cif();

  attn_coef_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .a_BRAM_dout       (a_dout),
    .a_BRAM_addrb      (a_addrb),
    .a_BRAM_load_done  (a_ld),
    .WH_BRAM_doutc     (wh_doutc),
    .WH_BRAM_addrc     (wh_addrc),
    .WH_BRAM_load_done (wh_ld),
    .WH_num_rows       (wh_nrows),
    .coef              (cif.master),
    .done              (done)
  );

  logic signed [DW-1:0] a_mem [32];
  logic [WHW-1:0]       wh_mem [64];

  always @(posedge clk) begin
    a_dout   <= a_mem[a_addrb];
    wh_doutc <= wh_mem[wh_addrc[5:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit seen_valid;
  always @(negedge clk) if (cif.coef_valid === 1'b1) seen_valid = 1'b1;

  int checks = 0;
  int failures = 0;

  int a_v [32];
  int rf_flag [64];
  int rf_nodes [64];
  int rf_f [64][16];
  int exp_c [64];
  int exp_l [64];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: e = src score of current group + dst dot of this row.
  task automatic build(input int n);
    int src, grp, cnt, ss, sd, e;
    logic [WHW-1:0] w;
    src = 0; grp = 0; cnt = 0;
    for (int j = 0; j < n; j++) begin
      ss = 0; sd = 0;
      for (int k = 0; k < NC; k++) begin
        ss += a_v[k] * rf_f[j][k];
        sd += a_v[NC+k] * rf_f[j][k];
      end
      if (rf_flag[j] != 0) begin
        src = ss; grp = rf_nodes[j]; cnt = 1;
      end else begin
        cnt++;
      end
      e = src + sd;
`ifdef LEAKY_RELU_EN
      if (e < 0) e = e >>> 3;
`endif
      exp_c[j] = e;
      exp_l[j] = (cnt == grp) ? 1 : 0;
      w = '0;
      for (int k = 0; k < NC; k++) w[WHW-1-DW*k -: DW] = 8'(rf_f[j][k]);
      w[8:1] = 8'(rf_nodes[j]);
      w[0] = (rf_flag[j] != 0);
      wh_mem[j] = w;
    end
    for (int i = 0; i < 32; i++) a_mem[i] = 8'(a_v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_ld = 1'b0; wh_ld = 1'b0;
    cif.coef_ready = 1'b0; wh_nrows = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", cif.coef_valid, 0);
    chk("rst_dout", cif.coef_dout, 0);
    chk("rst_last", cif.coef_last, 0);
    chk("rst_done", done, 0);
    chk("rst_addrc", wh_addrc, 0);
    chk("rst_addrb", a_addrb, 0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
  endtask

  task automatic start(input int n, input bit hold_hi);
    a_ld = 1'b1; wh_ld = 1'b1;
    wh_nrows = WHA'(n);
    cif.coef_ready = hold_hi;
    repeat (3) @(negedge clk);
    a_ld = 1'b0;
  endtask

  task automatic run_case(input int n, input int stall, input bit hold_hi);
    int t, prev;
    build(n);
    do_reset();
    start(n, hold_hi);
    prev = 0;
    for (int j = 0; j < n; j++) begin
      t = 0;
      while (cif.coef_valid !== 1'b1 && t < 200) begin
        @(negedge clk); t++;
      end
      if (cif.coef_valid !== 1'b1) begin
        chk("valid_timeout", 0, 1);
        return;
      end
      wh_ld = 1'b0;
      chk($sformatf("coef[%0d]", j), cif.coef_dout, exp_c[j]);
      chk($sformatf("last[%0d]", j), cif.coef_last, exp_l[j]);
      chk("done_low", done, 0);
      if (hold_hi && j > 0) chk("interval", cyc - prev, 4);
      prev = cyc;
      if (stall > 0 && j == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_coef", cif.coef_dout, exp_c[j]);
          chk("stall_valid", cif.coef_valid, 1);
          chk("stall_last", cif.coef_last, exp_l[j]);
          chk("stall_addrc", wh_addrc, j);
        end
      end
      if (!hold_hi) begin
        cif.coef_ready = 1'b1;
        @(negedge clk);
        cif.coef_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("done_high", done, 1);
    chk("valid_after_done", cif.coef_valid, 0);
    if (n == 0) chk("no_valid_seen", seen_valid, 0);
  endtask

  initial begin
    int t;
    a_ld = 1'b0; wh_ld = 1'b0; wh_nrows = '0;
    cif.coef_ready = 1'b0;
    for (int i = 0; i < 64; i++) wh_mem[i] = '0;

    // Single-row group, a all ones, features 2.
    for (int i = 0; i < 32; i++) a_v[i] = 1;
    rf_flag[0] = 1; rf_nodes[0] = 1;
    for (int k = 0; k < NC; k++) rf_f[0][k] = 2;
    run_case(1, 0, 1'b0);

    // Group of three, src=+1 dst=-1, with a 10-cycle stall.
    for (int i = 0; i < 32; i++) a_v[i] = (i < 16) ? 1 : -1;
    for (int j = 0; j < 3; j++) begin
      rf_flag[j] = (j == 0) ? 1 : 0;
      rf_nodes[j] = (j == 0) ? 3 : 0;
      for (int k = 0; k < NC; k++) rf_f[j][k] = j + 1;
    end
    run_case(3, 10, 1'b0);

    // Extremes.
    for (int i = 0; i < 32; i++) a_v[i] = -128;
    rf_flag[0] = 1; rf_nodes[0] = 1;
    for (int k = 0; k < NC; k++) rf_f[0][k] = -128;
    run_case(1, 0, 1'b0);

    // Empty WH.
    run_case(0, 0, 1'b0);

    // Random groups, ready held high.
    for (int i = 0; i < 32; i++) a_v[i] = int'($urandom_range(255)) - 128;
    for (int j = 0; j < 16; j++) begin
      rf_flag[j] = ($urandom_range(2) == 0) ? 1 : 0;
      rf_nodes[j] = int'($urandom_range(5, 1));
      for (int k = 0; k < NC; k++) rf_f[j][k] = int'($urandom_range(255)) - 128;
    end
    run_case(16, 0, 1'b1);

    // Reset while a coefficient is presented.
    for (int i = 0; i < 32; i++) a_v[i] = 1;
    rf_flag[0] = 1; rf_nodes[0] = 1;
    for (int k = 0; k < NC; k++) rf_f[0][k] = 2;
    build(1);
    do_reset();
    start(1, 1'b0);
    t = 0;
    while (cif.coef_valid !== 1'b1 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("midout_reached", cif.coef_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", cif.coef_valid, 0);
    chk("abort_dout", cif.coef_dout, 0);
    chk("abort_last", cif.coef_last, 0);
    chk("abort_done", done, 0);
    chk("abort_addrc", wh_addrc, 0);
    chk("abort_state", dut.r_state, IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
